tmds_encoder: RTL
=================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 SHALL have parameter RESET_TOKEN, default 10'b1101010100, meaning the tmds_out value while reset is asserted and on release.
REQ-002 SHALL have port clk_1x_in  input  1  pixel clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port data_in  input  8  pixel component byte.
REQ-005 SHALL have port de_in  input  1  data enable; 1 = video period, 0 = control period.
REQ-006 SHALL have port c0_in  input  1  control bit 0 (HSYNC on blue channel).
REQ-007 SHALL have port c1_in  input  1  control bit 1 (VSYNC on blue channel).
REQ-008 SHALL have port tmds_out  output  10  encoded symbol; bit 0 is transmitted first by the downstream serializer.
REQ-009 SHALL have port disparity_out  output  5  running disparity cnt, signed two's complement, for debug and verification.

Function
REQ-010 SHALL be a two-stage pipeline with fixed latency: inputs sampled on edge N appear encoded on tmds_out after edge N+2, for every cycle, with no stalls.
REQ-011 Stage 1 SHALL compute n1 = popcount(data_in) (4-bit).
REQ-012 Stage 1 SHALL select XNOR mode when n1>4, or when n1==4 and data_in[0]==0; otherwise it SHALL select XOR mode.
REQ-013 Stage 1 SHALL build q_m: q_m[0]=d[0]; for i=1..7, q_m[i]=q_m[i-1] XNOR d[i] (XNOR mode) or q_m[i-1] XOR d[i] (XOR mode); q_m[8]=0 in XNOR mode, 1 in XOR mode.
REQ-014 Stage 1 SHALL register q_m[8:0], qn1 = popcount(q_m[7:0]), de_in, c0_in and c1_in.
REQ-015 Stage 2 SHALL define qn0 = 8 - qn1; all cnt arithmetic SHALL be 5-bit signed with results confined to -8..+8, and no saturation is needed.
REQ-016 Stage 2, de=0: tmds_out SHALL be {c1,c0}=00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011, and cnt SHALL be set to 0.
REQ-017 Stage 2, de=1 and (cnt==0 or qn1==4): tmds_out SHALL be {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
REQ-018 In the REQ-017 case, cnt SHALL become cnt+(qn1-qn0) when q_m[8]=1, else cnt+(qn0-qn1).
REQ-019 Stage 2, de=1 and ((cnt>0 and qn1>4) or (cnt<0 and qn1<4)): tmds_out SHALL be {1, q_m[8], ~q_m[7:0]}, and cnt SHALL become cnt + 2*q_m[8] + (qn0-qn1).
REQ-020 Stage 2, de=1, all other cases: tmds_out SHALL be {0, q_m[8], q_m[7:0]}, and cnt SHALL become cnt - 2*(~q_m[8]) + (qn1-qn0).
REQ-021 tmds_out and disparity_out SHALL be registered outputs; disparity_out SHALL equal cnt after the same edge that updates tmds_out.
REQ-022 A de transition 1->0 SHALL produce a control token on the first control cycle with no residual data symbol; a transition 0->1 SHALL encode the first pixel starting from cnt=0.
REQ-023 Control inputs SHALL be ignored when de=1, and data_in SHALL be ignored when de=0.

Reset
REQ-024 While reset_in=1, tmds_out SHALL be RESET_TOKEN, disparity_out/cnt SHALL be 0, the stage-1 de SHALL be 0, the stage-1 c SHALL be 00, and the stage-1 q_m SHALL be 0.
REQ-025 Reset asserted mid-stream SHALL discard both pipeline stages immediately (asynchronously).
REQ-026 After reset release, the first two edges SHALL output control tokens derived from the flushed stage contents, i.e. RESET_TOKEN, before live data appears.

Verification
REQ-027 Reset, then de=1 with data 0x00 for 2 cycles -> tmds_out 0100000000 (cnt=-8), then 1111111111 (cnt=+2).
REQ-028 From cnt=0, de=1 with data 0xFF -> tmds_out 1000000000, cnt=-8.
REQ-029 de=0 with {c1,c0} stepped through 00, 01, 10, 11 -> 1101010100, 0010101011, 0101010100, 1010101011, each 2 cycles later, with disparity_out=0.
REQ-030 Random data at de=1 for 10^5 cycles -> cnt always in -8..+8; software-model decode recovers data_in exactly at 2-cycle lag; every data symbol has 3..7 ones or a cnt-correcting complement.
REQ-031 Pulse reset_in mid-video with cnt≠0 -> tmds_out=1101010100 and disparity_out=0 within the same cycle (asynchronous); data resumes with the correct symbol on the 3rd edge after release.
REQ-032 de toggled every cycle with data 0x10 -> data and control symbols interleave at exact 2-cycle latency, and cnt resets to 0 on each control cycle.

Source files
------------

// File: rtl/tmds_encoder.sv
// -----------------------------------------------------------------------------
// tmds_encoder
//   DVI/HDMI TMDS 8b/10b channel encoder as a fixed two-stage pipeline.
//   Stage 1 builds the transition-minimised word q_m and its ones count.
//   Stage 2 applies DC balancing against the running disparity (cnt), or
//   emits one of the four control tokens when de is low.
//
// Ports
//   clk_1x_in      in   1   pixel clock, rising edge
//   reset_in       in   1   asynchronous, active-high reset
//   data_in        in   8   pixel component byte
//   de_in          in   1   data enable (1 = video, 0 = control)
//   c0_in, c1_in   in   1   control bits (HSYNC / VSYNC on the blue channel)
//   tmds_out       out  10  encoded symbol, bit 0 serialised first
//   disparity_out  out  5   running disparity cnt, signed two's complement
// -----------------------------------------------------------------------------
module tmds_encoder #(
  parameter logic [9:0] RESET_TOKEN = 10'b1101010100
) (
  input  logic       clk_1x_in,
  input  logic       reset_in,
  input  logic [7:0] data_in,
  input  logic       de_in,
  input  logic       c0_in,
  input  logic       c1_in,
  output logic [9:0] tmds_out,
  output logic [4:0] disparity_out
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] f_popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // XNOR chaining is chosen for bytes with many ones so that q_m carries
  // fewer transitions; q_m[8] records which chaining was used.
  function automatic logic [8:0] f_build_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = f_popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8:0]        w_qm_p0;
  logic [3:0]        w_qn1_p0;

  logic              r_live;
  logic [8:0]        r_qm_p1;
  logic [3:0]        r_qn1_p1;
  logic              r_de_p1;
  logic [1:0]        r_c_p1;

  logic [9:0]        r_sym_p2;
  logic signed [4:0] r_cnt_p2;

  logic [4:0]        w_qn1_x2;
  logic signed [4:0] w_diff;
  logic              w_cnt_zero;
  logic              w_cnt_pos;
  logic              w_cnt_neg;
  logic [9:0]        w_sym_nxt;
  logic signed [4:0] w_cnt_nxt;

  // ---- stage 0 -> 1: transition minimisation ----
  assign w_qm_p0  = f_build_qm(data_in);
  assign w_qn1_p0 = f_popcount8(w_qm_p0[7:0]);

  // r_live holds stage 1 flushed for the first edge after reset release, so
  // two flushed control symbols leave the pipe before any live input.
  always_ff @(posedge clk_1x_in or posedge reset_in) begin
    if (reset_in) begin
      r_live   <= 1'b0;
      r_qm_p1  <= '0;
      r_qn1_p1 <= '0;
      r_de_p1  <= 1'b0;
      r_c_p1   <= 2'b00;
    end else begin
      r_live <= 1'b1;
      if (r_live) begin
        r_qm_p1  <= w_qm_p0;
        r_qn1_p1 <= w_qn1_p0;
        r_de_p1  <= de_in;
        r_c_p1   <= {c1_in, c0_in};
      end else begin
        r_qm_p1  <= '0;
        r_qn1_p1 <= '0;
        r_de_p1  <= 1'b0;
        r_c_p1   <= 2'b00;
      end
    end
  end

  // ---- stage 1 -> 2: DC balancing ----
  // w_diff is qn1 - qn0 = 2*qn1 - 8, formed modulo 32 and read as signed.
  assign w_qn1_x2   = {r_qn1_p1, 1'b0};
  assign w_diff     = $signed(w_qn1_x2 - 5'd8);
  assign w_cnt_zero = (r_cnt_p2 == 5'sd0);
  assign w_cnt_neg  = r_cnt_p2[4];
  assign w_cnt_pos  = !r_cnt_p2[4] && !w_cnt_zero;

  always_comb begin
    w_sym_nxt = RESET_TOKEN;
    w_cnt_nxt = 5'sd0;
    if (!r_de_p1) begin
      unique case (r_c_p1)
        2'b00:   w_sym_nxt = CTRL_00;
        2'b01:   w_sym_nxt = CTRL_01;
        2'b10:   w_sym_nxt = CTRL_10;
        default: w_sym_nxt = CTRL_11;
      endcase
      w_cnt_nxt = 5'sd0;
    end else if (w_cnt_zero || (r_qn1_p1 == 4'd4)) begin
      w_sym_nxt = {~r_qm_p1[8], r_qm_p1[8],
                   r_qm_p1[8] ? r_qm_p1[7:0] : ~r_qm_p1[7:0]};
      w_cnt_nxt = r_qm_p1[8] ? (r_cnt_p2 + w_diff) : (r_cnt_p2 - w_diff);
    end else if ((w_cnt_pos && (r_qn1_p1 > 4'd4)) ||
                 (w_cnt_neg && (r_qn1_p1 < 4'd4))) begin
      // Inverting the payload pulls cnt back toward zero.
      w_sym_nxt = {1'b1, r_qm_p1[8], ~r_qm_p1[7:0]};
      w_cnt_nxt = r_cnt_p2 + (r_qm_p1[8] ? 5'sd2 : 5'sd0) - w_diff;
    end else begin
      w_sym_nxt = {1'b0, r_qm_p1[8], r_qm_p1[7:0]};
      w_cnt_nxt = r_cnt_p2 - (r_qm_p1[8] ? 5'sd0 : 5'sd2) + w_diff;
    end
  end

  always_ff @(posedge clk_1x_in or posedge reset_in) begin
    if (reset_in) begin
      r_sym_p2 <= RESET_TOKEN;
      r_cnt_p2 <= 5'sd0;
    end else begin
      r_sym_p2 <= w_sym_nxt;
      r_cnt_p2 <= w_cnt_nxt;
    end
  end

  // ---- stage 2: outputs ----
  assign tmds_out      = r_sym_p2;
  assign disparity_out = r_cnt_p2;

endmodule
